// File: rtl/bs_pkg.sv
// Shared types and constants for the Battleship player engine.
package bs_pkg;

   localparam int unsigned DefaultCells = 16;

   typedef enum logic [2:0] {
      StLoad,
      StMyTurn,
      StSend,
      StTheirTurn,
      StWon,
      StLost
   } state_t;

   localparam logic [2:0] D_LOAD = 3'd0;
   localparam logic [2:0] D_FIRE = 3'd1;
   localparam logic [2:0] D_WAIT = 3'd2;
   localparam logic [2:0] D_WIN  = 3'd3;
   localparam logic [2:0] D_LOSE = 3'd4;

   function automatic logic [2:0] disp_of(input state_t s);
      logic [2:0] d;
      case (s)
         StMyTurn:    d = D_FIRE;
         StSend:      d = D_WAIT;
         StTheirTurn: d = D_WAIT;
         StWon:       d = D_WIN;
         StLost:      d = D_LOSE;
         default:     d = D_LOAD;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/bs_popcount.sv
// Combinational population count of a W-bit vector.
module bs_popcount #(
   parameter int unsigned W  = 16,
   parameter int unsigned OW = $clog2(W + 1)
) (
   input  logic [W-1:0]  in_i,
   output logic [OW-1:0] cnt_o
);

   always_comb begin
      cnt_o = '0;
      for (int unsigned i = 0; i < W; i++) begin
         cnt_o = cnt_o + OW'(in_i[i]);
      end
   end

endmodule

// File: rtl/bs_player_core.sv
// Per-player Battleship engine: ship placement, shot bookkeeping, turn sequencing and
// the valid/ready hand-off of the cumulative attack vector to the link layer.
module bs_player_core
   import bs_pkg::*;
#(
   parameter int unsigned CELLS = DefaultCells,
   parameter int unsigned SHOTS = 1,
   parameter int unsigned FIRST = 1,
   parameter int unsigned CNTW  = $clog2(CELLS + 1)
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             load_btn,
   input  logic [CELLS-1:0] ship_sw,
   input  logic [CELLS-1:0] atk_sw,
   input  logic             fire_btn,
   input  logic [CELLS-1:0] opp_atk,
   input  logic             opp_atk_valid,
   input  logic             opp_alive,
   output logic [CELLS-1:0] atk_out,
   output logic             atk_valid,
   input  logic             atk_ready,
   output logic [CELLS-1:0] ships,
   output logic [CNTW-1:0]  hits_taken,
   output logic [CNTW-1:0]  shots_fired,
   output logic             alive,
   output logic             bad_shot,
   output logic [2:0]       disp
);

   state_t           state_q, state_d;
   logic [CELLS-1:0] ships_q, ships_d;
   logic [CELLS-1:0] seen_q, seen_d;
   logic [CELLS-1:0] atk_out_q, atk_out_d;
   logic             atk_valid_q, atk_valid_d;
   logic [CNTW-1:0]  hits_q, hits_d;
   logic [CNTW-1:0]  shots_q, shots_d;
   logic             alive_q, alive_d;
   logic             bad_q, bad_d;
   logic [2:0]       disp_q;
   logic             fire_q, load_q;

   logic [CELLS-1:0] new_own, new_opp, hit_vec, ships_after;
   logic [CNTW-1:0]  cnt_own, cnt_opp, cnt_hit;
   logic             fire_rise, opp_retract;

   assign fire_rise   = fire_btn & ~fire_q;
   assign new_own     = atk_sw & ~atk_out_q;
   assign new_opp     = opp_atk & ~seen_q;
   assign hit_vec     = new_opp & ships_q;
   assign ships_after = ships_q & ~opp_atk;
   assign opp_retract = |(seen_q & ~opp_atk);

   bs_popcount #(.W(CELLS), .OW(CNTW)) u_pc_own (.in_i(new_own), .cnt_o(cnt_own));
   bs_popcount #(.W(CELLS), .OW(CNTW)) u_pc_opp (.in_i(new_opp), .cnt_o(cnt_opp));
   bs_popcount #(.W(CELLS), .OW(CNTW)) u_pc_hit (.in_i(hit_vec), .cnt_o(cnt_hit));

   always_comb begin
      state_d     = state_q;
      ships_d     = ships_q;
      seen_d      = seen_q;
      atk_out_d   = atk_out_q;
      atk_valid_d = atk_valid_q;
      hits_d      = hits_q;
      shots_d     = shots_q;
      alive_d     = alive_q;
      bad_d       = 1'b0;

      unique case (state_q)
         StLoad: begin
            if (load_btn) begin
               if (ship_sw != '0) begin
                  ships_d = ship_sw;
                  alive_d = 1'b1;
                  state_d = (FIRST != 0) ? StMyTurn : StTheirTurn;
               end else if (!load_q) begin
                  // Empty placement is flagged once per press, not for as long as it is held.
                  bad_d = 1'b1;
               end
            end
         end
         StMyTurn: begin
            if (!opp_alive) begin
               state_d = StWon;
            end else if (fire_rise) begin
               if (cnt_own == CNTW'(SHOTS)) begin
                  atk_out_d   = atk_out_q | new_own;
                  shots_d     = shots_q + CNTW'(SHOTS);
                  atk_valid_d = 1'b1;
                  state_d     = StSend;
               end else begin
                  bad_d = 1'b1;
               end
            end
         end
         StSend: begin
            if (!opp_alive) begin
               atk_valid_d = 1'b0;
               state_d     = StWon;
            end else if (atk_ready) begin
               atk_valid_d = 1'b0;
               state_d     = StTheirTurn;
            end
         end
         StTheirTurn: begin
            if (!opp_alive) begin
               state_d = StWon;
            end else if (opp_atk_valid) begin
               if (cnt_opp == CNTW'(SHOTS) && !opp_retract) begin
                  seen_d  = opp_atk;
                  ships_d = ships_after;
                  hits_d  = hits_q + cnt_hit;
                  if (ships_after == '0) begin
                     alive_d = 1'b0;
                     state_d = StLost;
                  end else begin
                     state_d = StMyTurn;
                  end
               end else begin
                  bad_d = 1'b1;
               end
            end
         end
         StWon, StLost: begin
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state_q     <= StLoad;
         ships_q     <= '0;
         seen_q      <= '0;
         atk_out_q   <= '0;
         atk_valid_q <= 1'b0;
         hits_q      <= '0;
         shots_q     <= '0;
         alive_q     <= 1'b0;
         bad_q       <= 1'b0;
         disp_q      <= D_LOAD;
         fire_q      <= 1'b0;
         load_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ships_q     <= ships_d;
         seen_q      <= seen_d;
         atk_out_q   <= atk_out_d;
         atk_valid_q <= atk_valid_d;
         hits_q      <= hits_d;
         shots_q     <= shots_d;
         alive_q     <= alive_d;
         bad_q       <= bad_d;
         disp_q      <= disp_of(state_q);
         fire_q      <= fire_btn;
         load_q      <= load_btn;
      end
   end

   assign atk_out     = atk_out_q;
   assign atk_valid   = atk_valid_q;
   assign ships       = ships_q;
   assign hits_taken  = hits_q;
   assign shots_fired = shots_q;
   assign alive       = alive_q;
   assign bad_shot    = bad_q;
   assign disp        = disp_q;

endmodule

// File: tb/tb_bs_player_core.sv
// Bench for bs_player_core: directed game scenarios on a 16-cell and a 64-cell board,
// then randomized 16-cell games checked against a turn-level reference model.
module tb_bs_player_core;
   import bs_pkg::*;

   logic clk = 1'b0;
   logic clr_n;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // 16-cell, 1 shot, this player first
   logic        load_btn, fire_btn, opp_atk_valid, opp_alive, atk_ready;
   logic [15:0] ship_sw, atk_sw, opp_atk, atk_out, ships;
   logic        atk_valid, alive, bad_shot;
   logic [4:0]  hits_taken, shots_fired;
   logic [2:0]  disp;

   // 64-cell, 2 shots, opponent first
   logic        load_btn_b, fire_btn_b, opp_atk_valid_b, opp_alive_b, atk_ready_b;
   logic [63:0] ship_sw_b, atk_sw_b, opp_atk_b, atk_out_b, ships_b;
   logic        atk_valid_b, alive_b, bad_shot_b;
   logic [6:0]  hits_taken_b, shots_fired_b;
   logic [2:0]  disp_b;

   bs_player_core #(.CELLS(16), .SHOTS(1), .FIRST(1)) dut_a (
      .clk(clk), .clr_n(clr_n), .load_btn(load_btn), .ship_sw(ship_sw), .atk_sw(atk_sw),
      .fire_btn(fire_btn), .opp_atk(opp_atk), .opp_atk_valid(opp_atk_valid),
      .opp_alive(opp_alive), .atk_out(atk_out), .atk_valid(atk_valid), .atk_ready(atk_ready),
      .ships(ships), .hits_taken(hits_taken), .shots_fired(shots_fired), .alive(alive),
      .bad_shot(bad_shot), .disp(disp)
   );

   bs_player_core #(.CELLS(64), .SHOTS(2), .FIRST(0)) dut_b (
      .clk(clk), .clr_n(clr_n), .load_btn(load_btn_b), .ship_sw(ship_sw_b),
      .atk_sw(atk_sw_b), .fire_btn(fire_btn_b), .opp_atk(opp_atk_b),
      .opp_atk_valid(opp_atk_valid_b), .opp_alive(opp_alive_b), .atk_out(atk_out_b),
      .atk_valid(atk_valid_b), .atk_ready(atk_ready_b), .ships(ships_b),
      .hits_taken(hits_taken_b), .shots_fired(shots_fired_b), .alive(alive_b),
      .bad_shot(bad_shot_b), .disp(disp_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr_n = 1'b0;
      step();
      step();
      clr_n = 1'b1;
   endtask

   task automatic load(input logic [15:0] s);
      ship_sw  = s;
      load_btn = 1'b1;
      step();
      load_btn = 1'b0;
   endtask

   task automatic fire(input logic [15:0] sw);
      atk_sw   = sw;
      fire_btn = 1'b1;
      step();
      fire_btn = 1'b0;
   endtask

   task automatic ack();
      atk_ready = 1'b1;
      step();
      atk_ready = 1'b0;
   endtask

   task automatic opp_shot(input logic [15:0] v);
      opp_atk       = v;
      opp_atk_valid = 1'b1;
      step();
      opp_atk_valid = 1'b0;
   endtask

   task automatic opp_shot_b(input logic [63:0] v);
      opp_atk_b       = v;
      opp_atk_valid_b = 1'b1;
      step();
      opp_atk_valid_b = 1'b0;
   endtask

   // Sets up to k currently-clear bits of m, starting the search at a random cell.
   function automatic logic [15:0] add_bits(input logic [15:0] m, input int k);
      logic [15:0] res;
      int          left;
      int          p;
      res  = m;
      left = k;
      p    = int'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) begin
         if (left > 0 && !res[(p + i) % 16]) begin
            res[(p + i) % 16] = 1'b1;
            left--;
         end
      end
      return res;
   endfunction

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired before completion");
      $fatal(1);
   end

   initial begin
      logic [15:0] m_ships, m_seen, m_atk, sw, ov, clr_bit;
      int          m_hits, m_shots, r;
      bit          mine, done, acc;

      load_btn = 0; fire_btn = 0; opp_atk_valid = 0; opp_alive = 1; atk_ready = 0;
      ship_sw = '0; atk_sw = '0; opp_atk = '0;
      load_btn_b = 0; fire_btn_b = 0; opp_atk_valid_b = 0; opp_alive_b = 1; atk_ready_b = 0;
      ship_sw_b = '0; atk_sw_b = '0; opp_atk_b = '0;
      clr_n = 1'b0;

      // Reset state
      do_reset();
      chk("rst_atk_out", atk_out, 0);
      chk("rst_atk_valid", atk_valid, 0);
      chk("rst_ships", ships, 0);
      chk("rst_hits", hits_taken, 0);
      chk("rst_shots", shots_fired, 0);
      chk("rst_alive", alive, 0);
      chk("rst_bad", bad_shot, 0);
      chk("rst_disp", disp, D_LOAD);
      chk("rst_b_disp", disp_b, D_LOAD);

      // Load
      load(16'h000F);
      chk("load_ships", ships, 16'h000F);
      chk("load_alive", alive, 1);
      step();
      chk("load_disp", disp, D_FIRE);

      // Two new cells rejected, then a single new cell accepted
      fire(16'h0011);
      chk("fire2_bad", bad_shot, 1);
      chk("fire2_valid", atk_valid, 0);
      step();
      chk("fire2_bad_once", bad_shot, 0);
      chk("fire2_disp", disp, D_FIRE);
      fire(16'h0010);
      chk("fire1_atk_out", atk_out, 16'h0010);
      chk("fire1_valid", atk_valid, 1);
      chk("fire1_shots", shots_fired, 1);
      chk("fire1_bad", bad_shot, 0);
      repeat (4) step();
      chk("send_hold_valid", atk_valid, 1);
      chk("send_disp", disp, D_WAIT);
      ack();
      chk("ack_valid", atk_valid, 0);
      step();
      chk("ack_disp", disp, D_WAIT);

      // Opponent hits cell 0
      opp_shot(16'h0001);
      chk("opp1_ships", ships, 16'h000E);
      chk("opp1_hits", hits_taken, 1);
      chk("opp1_bad", bad_shot, 0);
      step();
      chk("opp1_disp", disp, D_FIRE);

      // Retraction rejected; sequence runs to a loss
      fire(16'h0030);
      chk("fire3_atk_out", atk_out, 16'h0030);
      ack();
      opp_shot(16'h0000);
      chk("retract_bad", bad_shot, 1);
      chk("retract_ships", ships, 16'h000E);
      step();
      chk("retract_bad_once", bad_shot, 0);
      opp_shot(16'h0003);
      chk("opp3_ships", ships, 16'h000C);
      chk("opp3_hits", hits_taken, 2);
      fire(16'h0070);
      ack();
      opp_shot(16'h0007);
      chk("opp7_ships", ships, 16'h0008);
      fire(16'h00F0);
      chk("fire_f0_atk_out", atk_out, 16'h00F0);
      chk("fire_f0_shots", shots_fired, 4);
      ack();
      opp_shot(16'h000F);
      chk("lost_ships", ships, 0);
      chk("lost_hits", hits_taken, 4);
      chk("lost_alive", alive, 0);
      step();
      chk("lost_disp", disp, D_LOSE);
      opp_shot(16'h001F);
      chk("lost_ignore_bad", bad_shot, 0);
      chk("lost_ignore_hits", hits_taken, 4);
      chk("lost_ignore_disp", disp, D_LOSE);

      // Opponent dies during the send, with atk_ready in the same cycle
      do_reset();
      load(16'h000F);
      fire(16'h0001);
      chk("win_pre_valid", atk_valid, 1);
      opp_alive = 1'b0;
      atk_ready = 1'b1;
      step();
      atk_ready = 1'b0;
      opp_alive = 1'b1;
      chk("win_valid", atk_valid, 0);
      step();
      chk("win_disp", disp, D_WIN);
      fire(16'h0003);
      chk("win_terminal_valid", atk_valid, 0);
      chk("win_terminal_atk", atk_out, 16'h0001);

      // Clear during a pending send
      do_reset();
      load(16'h000F);
      fire(16'h0080);
      chk("clr_pre_valid", atk_valid, 1);
      clr_n = 1'b0;
      step();
      clr_n = 1'b1;
      chk("clr_valid", atk_valid, 0);
      chk("clr_atk_out", atk_out, 0);
      chk("clr_ships", ships, 0);
      chk("clr_shots", shots_fired, 0);
      chk("clr_alive", alive, 0);
      chk("clr_disp", disp, D_LOAD);

      // Wide board, two shots per turn, opponent first
      ship_sw_b  = 64'h000F;
      load_btn_b = 1'b1;
      step();
      load_btn_b = 1'b0;
      chk("b_load_ships", ships_b, 64'h000F);
      chk("b_load_alive", alive_b, 1);
      step();
      chk("b_load_disp", disp_b, D_WAIT);
      opp_shot_b(64'h0001);
      chk("b_one_bad", bad_shot_b, 1);
      chk("b_one_ships", ships_b, 64'h000F);
      step();
      chk("b_one_bad_once", bad_shot_b, 0);
      opp_shot_b(64'h0003);
      chk("b_two_bad", bad_shot_b, 0);
      chk("b_two_ships", ships_b, 64'h000C);
      chk("b_two_hits", hits_taken_b, 2);
      step();
      chk("b_two_disp", disp_b, D_FIRE);
      atk_sw_b   = 64'h8000_0000_0000_0001;
      fire_btn_b = 1'b1;
      step();
      fire_btn_b = 1'b0;
      chk("b_fire_atk_out", atk_out_b, 64'h8000_0000_0000_0001);
      chk("b_fire_valid", atk_valid_b, 1);
      chk("b_fire_shots", shots_fired_b, 2);

      // Randomized games against the turn-level model
      for (int g = 0; g < 16; g++) begin
         do_reset();
         chk("g_rst_valid", atk_valid, 0);
         chk("g_rst_disp", disp, D_LOAD);
         m_ships = 16'($urandom);
         if (m_ships == 0) m_ships = 16'h8000;
         m_seen = '0; m_atk = '0; m_hits = 0; m_shots = 0;
         mine = 1'b1; done = 1'b0;
         load(m_ships);
         chk("g_load_ships", ships, m_ships);
         for (int t = 0; t < 60 && !done; t++) begin
            step();
            chk("g_turn_disp", disp, mine ? D_FIRE : D_WAIT);
            r = int'($urandom_range(0, 11));
            if (r == 0) begin
               opp_alive = 1'b0;
               step();
               opp_alive = 1'b1;
               step();
               chk("g_win_disp", disp, D_WIN);
               chk("g_win_valid", atk_valid, 0);
               done = 1'b1;
            end else if (mine) begin
               sw = m_atk & 16'($urandom);
               sw = add_bits(sw | m_atk, (r == 1) ? 2 : ((r == 2) ? 0 : 1)) & ~(m_atk & ~sw);
               acc = ($countones(sw & ~m_atk) == 1);
               fire(sw);
               if (acc) begin
                  m_atk   = m_atk | sw;
                  m_shots = m_shots + 1;
               end
               chk("g_fire_bad", bad_shot, !acc);
               chk("g_fire_atk_out", atk_out, m_atk);
               chk("g_fire_shots", shots_fired, m_shots);
               chk("g_fire_valid", atk_valid, acc);
               step();
               chk("g_fire_bad_once", bad_shot, 0);
               chk("g_fire_disp", disp, acc ? D_WAIT : D_FIRE);
               if (acc) begin
                  repeat ($urandom_range(0, 4)) step();
                  chk("g_send_hold", atk_valid, 1);
                  if ($urandom_range(0, 9) == 0) begin
                     clr_n = 1'b0;
                     step();
                     clr_n = 1'b1;
                     chk("g_clr_valid", atk_valid, 0);
                     chk("g_clr_atk_out", atk_out, 0);
                     done = 1'b1;
                  end else begin
                     ack();
                     chk("g_ack_valid", atk_valid, 0);
                     mine = 1'b0;
                  end
               end
            end else begin
               clr_bit = add_bits(~m_seen, 1) ^ ~m_seen;
               if (r <= 7)       ov = add_bits(m_seen, 1);
               else if (r == 8)  ov = add_bits(m_seen, 2);
               else if (r == 9)  ov = m_seen;
               else              ov = add_bits(m_seen, 1) & ~clr_bit;
               acc = ($countones(ov & ~m_seen) == 1) && ((m_seen & ~ov) == 0);
               opp_shot(ov);
               if (acc) begin
                  m_hits  = m_hits + $countones(ov & ~m_seen & m_ships);
                  m_ships = m_ships & ~ov;
                  m_seen  = ov;
               end
               chk("g_opp_bad", bad_shot, !acc);
               chk("g_opp_ships", ships, m_ships);
               chk("g_opp_hits", hits_taken, m_hits);
               chk("g_opp_alive", alive, m_ships != 0);
               step();
               chk("g_opp_bad_once", bad_shot, 0);
               if (acc && m_ships == 0) begin
                  chk("g_lose_disp", disp, D_LOSE);
                  done = 1'b1;
               end else begin
                  chk("g_opp_disp", disp, acc ? D_FIRE : D_WAIT);
                  mine = acc;
               end
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bs_player_core.md
Name: bs_player_core

Overview:
Parametrised per-player Battleship engine. Holds ship placement, tracks own and opponent shot history, and validates each turn's shot count. Computes hits and sends the attack vector to the link layer (UART) via a valid/ready handshake. One instance per board; opponent data arrives from the link.

Parameters:
CELLS, 16, board cells; one bit per cell in every board vector.
SHOTS, 1, new cells required per turn (1..CELLS).
FIRST, 1, 1 = this player fires first after loading; 0 = opponent fires first.
CNTW, $clog2(CELLS+1), width of all counters.

Ports:
clk  in  1  system clock; all state updates on rising edge.
clr_n  in  1  synchronous active-low reset; also serves as game clear.
load_btn  in  1  both-player load request (level); acted on in S_LOAD only.
ship_sw  in  CELLS  ship placement switches.
atk_sw  in  CELLS  cumulative attack switches.
fire_btn  in  1  fire request; an internal rising-edge detector is used.
opp_atk  in  CELLS  opponent cumulative attack vector from the link.
opp_atk_valid  in  1  1-cycle strobe; opp_atk is valid this cycle.
opp_alive  in  1  opponent alive flag from the link.
atk_out  out  CELLS  registered cumulative attack vector sent to the opponent.
atk_valid  out  1  high while atk_out awaits link acceptance.
atk_ready  in  1  link accepts atk_out when atk_valid & atk_ready.
ships  out  CELLS  surviving ship cells (LED drive).
hits_taken  out  CNTW  opponent hits landed on this board.
shots_fired  out  CNTW  popcount of atk_out.
alive  out  1  ships != 0 after loading.
bad_shot  out  1  1-cycle pulse on a rejected own or opponent shot.
disp  out  3  game status code for the 7-seg word driver.

Behaviour:
- Reset (clr_n=0 at an edge):
  - State = S_LOAD.
  - All registers, counters and outputs = 0, except alive=0 and disp=D_LOAD.
  - Reset mid-handshake drops atk_valid the same edge; no completion is implied.
- States: S_LOAD, S_MY_TURN, S_SEND, S_THEIR_TURN, S_WON, S_LOST.
- S_LOAD:
  - load_btn=1 and ship_sw!=0 → ships<=ship_sw, alive<=1, next = FIRST ? S_MY_TURN : S_THEIR_TURN.
  - ship_sw==0 → stay; bad_shot pulses.
- S_MY_TURN, on a fire_btn rise:
  - new = atk_sw & ~atk_out.
  - popcount(new)==SHOTS → atk_out<=atk_out|new, shots_fired += SHOTS, → S_SEND.
  - Otherwise → bad_shot pulse, stay.
  - Cleared switch bits never remove prior shots (atk_out is monotonic).
- S_SEND:
  - atk_valid=1; atk_out is stable.
  - On atk_valid & atk_ready → atk_valid<=0 next cycle, → S_THEIR_TURN.
  - No timeout; holds indefinitely.
- S_THEIR_TURN, on opp_atk_valid:
  - newo = opp_atk & ~seen (seen is an internal CELLS register).
  - popcount(newo)==SHOTS:
    - seen<=opp_atk.
    - hit = newo & ships.
    - ships<=ships & ~opp_atk.
    - hits_taken += popcount(hit).
    - Next: S_LOST if the updated ships==0, else S_MY_TURN.
  - opp_atk clearing previously seen bits, or a wrong count → bad_shot, state and registers unchanged.
  - opp_atk_valid in any other state is ignored; no bad_shot.
- opp_alive==0 in S_MY_TURN, S_SEND or S_THEIR_TURN → S_WON. This takes priority over any same-cycle event; an in-flight S_SEND is abandoned (atk_valid<=0).
- S_LOST: alive<=0.
- S_WON and S_LOST are terminal until clr_n.
- disp = D_LOAD/D_FIRE/D_WAIT/D_WAIT/D_WIN/D_LOSE for states in the order above. disp is registered (1-cycle latency from state).
- Counter width: CNTW bits; no saturation needed (max CELLS).
- bad_shot is the registered OR of all reject conditions and is never high two cycles in a row for a single event.

Decomposition:
- Package bs_pkg: state enum state_t, disp codes (D_LOAD=0, D_FIRE=1, D_WAIT=2, D_WIN=3, D_LOSE=4), default CELLS.
- Sub-module bs_popcount #(W) (combinational, W → $clog2(W+1)). It is instanced three times: own new shots, opponent new shots, hits.
- Edge detector for fire_btn is inline.

Test Plan:
1. CELLS=16, SHOTS=1, FIRST=1. clr_n=0 then 1; ship_sw=16'h000F, load_btn=1 → ships=000F, alive=1, disp=D_FIRE.
2. In S_MY_TURN, atk_sw=16'h0011 (two new), fire rise → bad_shot one cycle, state stays. Then atk_sw=16'h0010, fire → atk_out=0010, atk_valid=1; atk_ready after 5 cycles → atk_valid low next cycle, disp=D_WAIT, shots_fired=1.
3. In S_THEIR_TURN:
   - opp_atk=0001, valid → ships=000E, hits_taken=1, state S_MY_TURN.
   - Later opp_atk=0000 (retracts a seen bit) → bad_shot, ships unchanged.
4. Sequence opp shots 0001, 0003, 0007, 000F across turns → after the last, ships=0, alive=0, disp=D_LOSE. Further opp_atk_valid strobes are ignored.
5. opp_alive drops while atk_valid=1 in S_SEND → atk_valid=0 next edge, disp=D_WIN; a simultaneous atk_ready has no effect.
6. clr_n=0 during S_SEND with atk_out=00F0 → all outputs 0, disp=D_LOAD. Repeat scenario 1 with CELLS=64, SHOTS=2, FIRST=0 → start in S_THEIR_TURN; a 2-new-bit opp shot is accepted and a 1-bit shot is rejected.
